// File: rtl/pipe_pkg.sv
// pipe_pkg -- shared types for the EX/MEM pipeline register slice.
//   XLEN, REG_AW   : default datapath / register-index widths
//   ex_mem_pkt_t   : packet carried from EX to MEM
//   PKT_W          : packed width of ex_mem_pkt_t
//   buf_state_t    : occupancy of the buffering stage (EMPTY, ONE, TWO)
//   pkt_bits()     : packet width for a given XLEN/REG_AW
package pipe_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  typedef struct packed {
    logic              reg_write;
    logic [1:0]        result_src;
    logic              mem_write;
    logic [XLEN-1:0]   alu_result;
    logic [XLEN-1:0]   write_data;
    logic [XLEN-1:0]   pc;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   pc_plus4;
    logic [XLEN-1:0]   auipc;
    logic [2:0]        funct3;
  } ex_mem_pkt_t;

  localparam int unsigned PKT_W = $bits(ex_mem_pkt_t);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_t;

  // 4 control bits + five XLEN fields + rd + funct3
  function automatic int unsigned pkt_bits(input int unsigned xlen,
                                           input int unsigned reg_aw);
    return 4 + 5 * xlen + reg_aw + 3;
  endfunction

endpackage

// File: rtl/pipe_ex_mem_stage_if.sv
// pipe_ex_mem_stage_if -- valid/ready bus around the EX/MEM stage.
//   in_valid/in_ready/in_pkt    : EX side
//   out_valid/out_ready/out_pkt : MEM side
//   master : environment (drives in_valid, in_pkt, out_ready)
//   slave  : the stage
interface pipe_ex_mem_stage_if;
  import pipe_pkg::*;

  logic        in_valid;
  logic        in_ready;
  ex_mem_pkt_t in_pkt;
  logic        out_valid;
  logic        out_ready;
  ex_mem_pkt_t out_pkt;

  modport master (
    output in_valid, in_pkt, out_ready,
    input  in_ready, out_valid, out_pkt
  );

  modport slave (
    input  in_valid, in_pkt, out_ready,
    output in_ready, out_valid, out_pkt
  );
endinterface

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf -- generic valid/ready register slice with flush.
//   clk, rst (sync, active-high), flush
//   in_valid/in_ready/in_data, out_valid/out_ready/out_data (W bits)
//   SKID_EN=1 : two-entry skid, registered in_ready, full throughput
//   SKID_EN=0 : one register, in_ready = !out_valid | out_ready
// out_data only changes on a load, so it holds its last value when empty.
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int unsigned W       = 8,
  parameter bit          SKID_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  buf_state_t   state_q;
  logic [W-1:0] main_q;
  logic         out_xfer;

  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign out_xfer  = out_valid & out_ready;

  if (SKID_EN) begin : g_skid
    logic [W-1:0] skid_q;
    logic         rdy_q;
    logic         acc;

    // rdy_q tracks (state_q != TWO) as a register of its own
    assign in_ready = rdy_q;
    assign acc      = in_valid & rdy_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= EMPTY;
        main_q  <= '0;
        skid_q  <= '0;
        rdy_q   <= 1'b1;
      end else if (flush) begin
        state_q <= EMPTY;
        rdy_q   <= 1'b1;
      end else begin
        unique case (state_q)
          EMPTY: begin
            if (acc) begin
              main_q  <= in_data;
              state_q <= ONE;
            end
          end
          ONE: begin
            if (acc && out_xfer) begin
              main_q <= in_data;
            end else if (acc) begin
              skid_q  <= in_data;
              state_q <= TWO;
              rdy_q   <= 1'b0;
            end else if (out_xfer) begin
              state_q <= EMPTY;
            end
          end
          TWO: begin
            if (out_xfer) begin
              main_q  <= skid_q;
              state_q <= ONE;
              rdy_q   <= 1'b1;
            end
          end
          default: begin
            state_q <= EMPTY;
            rdy_q   <= 1'b1;
          end
        endcase
      end
    end
  end else begin : g_single
    logic acc;

    assign in_ready = ~out_valid | out_ready;
    assign acc      = in_valid & in_ready;

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= EMPTY;
        main_q  <= '0;
      end else if (flush) begin
        state_q <= EMPTY;
      end else if (acc) begin
        main_q  <= in_data;
        state_q <= ONE;
      end else if (out_xfer) begin
        state_q <= EMPTY;
      end
    end
  end

endmodule

// File: rtl/pipe_ex_mem_stage.sv
// pipe_ex_mem_stage -- EX/MEM pipeline register.
//   clk, rst (sync, active-high), flush (drop held + incoming packets)
//   bus : pipe_ex_mem_stage_if.slave (in_valid/in_ready/in_pkt,
//         out_valid/out_ready/out_pkt)
//   EX_MEM_PERF_EN defined: extra outputs stall_cnt, flush_cnt (32-bit,
//   saturating); PERF_CNT_INIT sets their reset value (normally 0).
// reg_write/mem_write are forced low whenever no packet is presented so a
// bubble can never write the register file or memory.
module pipe_ex_mem_stage #(
  parameter int unsigned XLEN    = pipe_pkg::XLEN,
  parameter int unsigned REG_AW  = pipe_pkg::REG_AW,
  parameter bit          SKID_EN = 1'b1
`ifdef EX_MEM_PERF_EN
  ,
  parameter logic [31:0] PERF_CNT_INIT = '0
`endif
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  pipe_ex_mem_stage_if.slave         bus
`ifdef EX_MEM_PERF_EN
  ,
  output logic [31:0]                stall_cnt,
  output logic [31:0]                flush_cnt
`endif
);

  // Packet layout comes from pipe_pkg; the buffer width follows the
  // parameters and equals PKT_W for the package defaults.
  localparam int unsigned DW = pipe_pkg::pkt_bits(XLEN, REG_AW);

  logic [DW-1:0]         held;
  pipe_pkg::ex_mem_pkt_t held_pkt;
  logic                  out_valid_w;
  logic                  in_ready_w;

  pipe_skid_buf #(
    .W       (DW),
    .SKID_EN (SKID_EN)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (bus.in_valid),
    .in_ready  (in_ready_w),
    .in_data   (bus.in_pkt),
    .out_valid (out_valid_w),
    .out_ready (bus.out_ready),
    .out_data  (held)
  );

  assign held_pkt      = held;
  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_w;

  always_comb begin
    bus.out_pkt           = held_pkt;
    bus.out_pkt.reg_write = held_pkt.reg_write & out_valid_w;
    bus.out_pkt.mem_write = held_pkt.mem_write & out_valid_w;
  end

`ifdef EX_MEM_PERF_EN
  logic [31:0] stall_q;
  logic [31:0] flush_q;

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

  // State TWO always has out_valid set, so out_valid alone marks
  // "something held" for the flush count.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= PERF_CNT_INIT;
      flush_q <= PERF_CNT_INIT;
    end else begin
      if (out_valid_w && !bus.out_ready && (stall_q != '1))
        stall_q <= stall_q + 32'd1;
      if (flush && out_valid_w && (flush_q != '1))
        flush_q <= flush_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ex_mem_stage.sv
// Directed self-checking bench for pipe_ex_mem_stage (SKID_EN=1).
// Inputs change 1 ns after each rising edge; outputs are checked there.
module tb_pipe_ex_mem_stage;
  import pipe_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pipe_ex_mem_stage_if u_if ();

`ifdef EX_MEM_PERF_EN
  logic [31:0] stall_cnt, flush_cnt, stall_cnt2, flush_cnt2;
  pipe_ex_mem_stage_if u_if2 ();
  assign u_if2.in_valid  = u_if.in_valid;
  assign u_if2.in_pkt    = u_if.in_pkt;
  assign u_if2.out_ready = u_if.out_ready;
`endif

  pipe_ex_mem_stage #(
    .XLEN    (32),
    .REG_AW  (5),
    .SKID_EN (1'b1)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (u_if)
`ifdef EX_MEM_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

`ifdef EX_MEM_PERF_EN
  pipe_ex_mem_stage #(
    .XLEN          (32),
    .REG_AW        (5),
    .SKID_EN       (1'b1),
    .PERF_CNT_INIT (32'hFFFF_FFFE)
  ) dut_sat (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (u_if2),
    .stall_cnt (stall_cnt2),
    .flush_cnt (flush_cnt2)
  );
`endif

  function automatic ex_mem_pkt_t mk(input logic [31:0] alu, input logic rw,
                                     input logic mw, input logic [4:0] rd);
    ex_mem_pkt_t p;
    p            = '0;
    p.reg_write  = rw;
    p.result_src = 2'b01;
    p.mem_write  = mw;
    p.alu_result = alu;
    p.write_data = ~alu;
    p.pc         = alu << 2;
    p.rd         = rd;
    p.pc_plus4   = (alu << 2) + 32'd4;
    p.auipc      = alu + 32'h1000;
    p.funct3     = 3'b010;
    return p;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    u_if.in_valid  = 1'b0;
    u_if.in_pkt    = '0;
    u_if.out_ready = 1'b0;

    // reset held for two edges with a packet offered
    rst = 1'b1;
    u_if.in_valid  = 1'b1;
    u_if.in_pkt    = mk(32'h55, 1'b1, 1'b1, 5'd3);
    u_if.out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_out_valid", u_if.out_valid, 1'b0);
      check("rst_in_ready", u_if.in_ready, 1'b1);
      check("rst_pkt_zero", (u_if.out_pkt === '0), 1'b1);
    end
    rst = 1'b0;
    #1;
    check("no_comb_path", u_if.out_valid, 1'b0);
    step();
    check("first_out_valid", u_if.out_valid, 1'b1);
    check("first_alu", u_if.out_pkt.alu_result, 32'h55);
    check("first_pkt", (u_if.out_pkt === mk(32'h55, 1'b1, 1'b1, 5'd3)), 1'b1);
    u_if.in_valid = 1'b0;
    step();
    check("drain_out_valid", u_if.out_valid, 1'b0);
    check("drain_rw_gated", u_if.out_pkt.reg_write, 1'b0);
    check("drain_alu_kept", u_if.out_pkt.alu_result, 32'h55);

    // streaming, one packet per cycle
    u_if.in_valid  = 1'b1;
    u_if.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      u_if.in_pkt = mk(32'h10 + 32'(i), 1'b1, 1'b0, 5'(i));
      step();
      check("stream_out_valid", u_if.out_valid, 1'b1);
      check("stream_alu", u_if.out_pkt.alu_result, 32'h10 + 32'(i));
      check("stream_in_ready", u_if.in_ready, 1'b1);
    end
    u_if.in_valid = 1'b0;
    step();
    check("stream_end_valid", u_if.out_valid, 1'b0);

    // backpressure into the skid register
    u_if.in_valid  = 1'b1;
    u_if.in_pkt    = mk(32'hA0, 1'b1, 1'b0, 5'd1);
    u_if.out_ready = 1'b1;
    step();
    check("bp_a0", u_if.out_pkt.alu_result, 32'hA0);
    u_if.out_ready = 1'b0;
    u_if.in_pkt    = mk(32'hA1, 1'b1, 1'b0, 5'd2);
    step();
    check("bp_two_in_ready", u_if.in_ready, 1'b0);
    check("bp_two_alu", u_if.out_pkt.alu_result, 32'hA0);
    u_if.in_pkt = mk(32'hA2, 1'b1, 1'b0, 5'd3);
    for (int i = 0; i < 2; i++) begin
      step();
      check("bp_hold_in_ready", u_if.in_ready, 1'b0);
      check("bp_hold_valid", u_if.out_valid, 1'b1);
      check("bp_hold_alu", u_if.out_pkt.alu_result, 32'hA0);
    end
    u_if.out_ready = 1'b1;
    step();
    check("bp_rel_a1", u_if.out_pkt.alu_result, 32'hA1);
    check("bp_rel_in_ready", u_if.in_ready, 1'b1);
    step();
    check("bp_rel_a2", u_if.out_pkt.alu_result, 32'hA2);
    check("bp_rel_a2_valid", u_if.out_valid, 1'b1);
    u_if.in_valid = 1'b0;
    step();
    check("bp_done_valid", u_if.out_valid, 1'b0);

    // flush from state TWO with a packet offered
    u_if.in_valid  = 1'b1;
    u_if.out_ready = 1'b0;
    u_if.in_pkt    = mk(32'hB0, 1'b1, 1'b1, 5'd7);
    step();
    u_if.in_pkt = mk(32'hB1, 1'b1, 1'b1, 5'd8);
    step();
    check("fl_pre_in_ready", u_if.in_ready, 1'b0);
    flush = 1'b1;
    u_if.in_pkt = mk(32'hB2, 1'b1, 1'b1, 5'd9);
    step();
    check("fl_out_valid", u_if.out_valid, 1'b0);
    check("fl_rw", u_if.out_pkt.reg_write, 1'b0);
    check("fl_mw", u_if.out_pkt.mem_write, 1'b0);
    check("fl_in_ready", u_if.in_ready, 1'b1);
    flush = 1'b0;
    u_if.in_valid  = 1'b0;
    u_if.out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("fl_after_valid", u_if.out_valid, 1'b0);
    end

    // bubble gating of write enables
    u_if.in_valid = 1'b1;
    u_if.in_pkt   = mk(32'hC0, 1'b1, 1'b1, 5'd5);
    step();
    check("g_rw", u_if.out_pkt.reg_write, 1'b1);
    check("g_mw", u_if.out_pkt.mem_write, 1'b1);
    check("g_rd", u_if.out_pkt.rd, 5'd5);
    u_if.in_valid = 1'b0;
    step();
    check("g_bub_valid", u_if.out_valid, 1'b0);
    check("g_bub_rw", u_if.out_pkt.reg_write, 1'b0);
    check("g_bub_mw", u_if.out_pkt.mem_write, 1'b0);
    check("g_bub_rd", u_if.out_pkt.rd, 5'd5);

    // reset while two packets are held
    u_if.in_valid  = 1'b1;
    u_if.out_ready = 1'b0;
    u_if.in_pkt    = mk(32'hD0, 1'b1, 1'b0, 5'd10);
    step();
    u_if.in_pkt = mk(32'hD1, 1'b1, 1'b0, 5'd11);
    step();
    check("rm_pre_in_ready", u_if.in_ready, 1'b0);
    rst = 1'b1;
    step();
    check("rm_out_valid", u_if.out_valid, 1'b0);
    check("rm_in_ready", u_if.in_ready, 1'b1);
    check("rm_pkt_zero", (u_if.out_pkt === '0), 1'b1);
    rst = 1'b0;
    u_if.in_pkt    = mk(32'hD2, 1'b1, 1'b0, 5'd12);
    u_if.out_ready = 1'b1;
    step();
    check("rm_first_valid", u_if.out_valid, 1'b1);
    check("rm_first_alu", u_if.out_pkt.alu_result, 32'hD2);
    u_if.in_valid = 1'b0;
    step();
    check("rm_end_valid", u_if.out_valid, 1'b0);

`ifdef EX_MEM_PERF_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("pf_rst_stall", stall_cnt, 32'd0);
    check("pf_rst_flush", flush_cnt, 32'd0);
    check("pf_sat_rst", stall_cnt2, 32'hFFFF_FFFE);
    u_if.in_valid  = 1'b1;
    u_if.out_ready = 1'b0;
    u_if.in_pkt    = mk(32'hE0, 1'b1, 1'b0, 5'd1);
    step();
    u_if.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("pf_stall3", stall_cnt, 32'd3);
    check("pf_sat_stall", stall_cnt2, 32'hFFFF_FFFF);
    flush = 1'b1;
    u_if.out_ready = 1'b1;
    step();
    flush = 1'b0;
    check("pf_flush1", flush_cnt, 32'd1);
    check("pf_stall_after", stall_cnt, 32'd3);
    u_if.in_valid  = 1'b1;
    u_if.out_ready = 1'b0;
    u_if.in_pkt    = mk(32'hE1, 1'b1, 1'b0, 5'd2);
    step();
    u_if.in_valid = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("pf_flush2", flush_cnt, 32'd2);
    check("pf_sat_flush", flush_cnt2, 32'hFFFF_FFFF);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
